// File: rtl/ex_muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared pipeline types: ALU control codes, mul/div op codes
//                and sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_DIVU = 2'b01,
        MD_REMU = 2'b10,
        MD_RSVD = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_sequencer_if
//  Description : Request/response handshake bundle of the mul/div sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_muldiv_sequencer_if
    import pipeline_pkg::*;
#(
    parameter int REG_WIDTH = 64
);
    logic                 req_valid;
    logic                 req_ready;
    muldiv_op_e           req_op;
    logic [REG_WIDTH-1:0] req_a;
    logic [REG_WIDTH-1:0] req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [REG_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_sequencer_alu_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : alu_port_mux
//  Description : Selects pipeline or sequencer drive onto the shared ALU ports.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_port_mux #(
    parameter int REG_WIDTH     = 64,
    parameter int ALU_CTRL_BITS = 5
) (
    input  wire logic                     seq_own_i,
    input  wire logic [REG_WIDTH-1:0]     pipe_rs1_i,
    input  wire logic [REG_WIDTH-1:0]     pipe_rs2_i,
    input  wire logic [REG_WIDTH-1:0]     pipe_imm_i,
    input  wire logic [ALU_CTRL_BITS-1:0] pipe_alu_ctrl_i,
    input  wire logic [REG_WIDTH-1:0]     seq_rs1_i,
    input  wire logic [REG_WIDTH-1:0]     seq_rs2_i,
    input  wire logic [REG_WIDTH-1:0]     seq_imm_i,
    input  wire logic [ALU_CTRL_BITS-1:0] seq_alu_ctrl_i,
    output logic      [REG_WIDTH-1:0]     alu_rs1_o,
    output logic      [REG_WIDTH-1:0]     alu_rs2_o,
    output logic      [REG_WIDTH-1:0]     alu_imm_o,
    output logic      [ALU_CTRL_BITS-1:0] alu_ctrl_o
);
    always_comb begin
        alu_rs1_o  = seq_own_i ? seq_rs1_i      : pipe_rs1_i;
        alu_rs2_o  = seq_own_i ? seq_rs2_i      : pipe_rs2_i;
        alu_imm_o  = seq_own_i ? seq_imm_i      : pipe_imm_i;
        alu_ctrl_o = seq_own_i ? seq_alu_ctrl_i : pipe_alu_ctrl_i;
    end
endmodule
`default_nettype wire

// File: rtl/ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_sequencer
//  Description : Multi-cycle MUL/DIVU/REMU sequencer borrowing the EX-stage ALU
//                (shift-add multiply, restoring divide).
//  Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv_sequencer
    import pipeline_pkg::*;
#(
    parameter int REG_WIDTH     = 64,
    parameter int ALU_CTRL_BITS = 5,
    parameter int CNT_W         = $clog2(REG_WIDTH) + 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    ex_muldiv_sequencer_if.slave          bus,
    input  wire logic                     flush_i,
    output logic                          stall_o,
    input  wire logic [REG_WIDTH-1:0]     pipe_rs1_i,
    input  wire logic [REG_WIDTH-1:0]     pipe_rs2_i,
    input  wire logic [REG_WIDTH-1:0]     pipe_imm_i,
    input  wire logic [ALU_CTRL_BITS-1:0] pipe_alu_ctrl_i,
    output logic      [REG_WIDTH-1:0]     alu_rs1_o,
    output logic      [REG_WIDTH-1:0]     alu_rs2_o,
    output logic      [REG_WIDTH-1:0]     alu_imm_o,
    output logic      [ALU_CTRL_BITS-1:0] alu_ctrl_o,
    input  wire logic [REG_WIDTH-1:0]     alu_out_i
);
    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(REG_WIDTH - 1);

    seq_state_e           state_q;
    muldiv_op_e           op_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [REG_WIDTH-1:0] acc_q;
    logic [REG_WIDTH-1:0] mcand_q;
    logic [REG_WIDTH-1:0] mplr_q;
    logic [REG_WIDTH-1:0] rem_q;
    logic [REG_WIDTH-1:0] quo_q;
    logic [REG_WIDTH-1:0] dvsr_q;
    logic                 resp_valid_q;
    logic [REG_WIDTH-1:0] resp_data_q;

    logic                     w_is_mul;
    logic [REG_WIDTH:0]       w_rem_sh;
    logic                     w_rem_ge;
    logic [REG_WIDTH-1:0]     w_seq_rs1;
    logic [REG_WIDTH-1:0]     w_seq_rs2;
    logic [ALU_CTRL_BITS-1:0] w_seq_ctrl;
    logic [REG_WIDTH-1:0]     w_result;

    // The trial compare is one bit wider than the ALU so that a shifted-out
    // remainder MSB still counts as "greater than the divisor".
    always_comb begin
        w_is_mul   = (op_q == MD_MUL);
        w_rem_sh   = {rem_q, quo_q[REG_WIDTH-1]};
        w_rem_ge   = (w_rem_sh >= {1'b0, dvsr_q});
        w_seq_rs1  = w_is_mul ? acc_q   : w_rem_sh[REG_WIDTH-1:0];
        w_seq_rs2  = w_is_mul ? mcand_q : dvsr_q;
        w_seq_ctrl = w_is_mul ? ALU_CTRL_BITS'(ALU_ADD) : ALU_CTRL_BITS'(ALU_SUB);
    end

    always_comb begin
        w_result = acc_q;
        case (op_q)
            MD_DIVU: w_result = quo_q;
            MD_REMU: w_result = rem_q;
            default: w_result = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= MD_MUL;
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplr_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else if (flush_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        mcand_q <= bus.req_a;
                        mplr_q  <= bus.req_b;
                        rem_q   <= '0;
                        quo_q   <= bus.req_a;
                        dvsr_q  <= bus.req_b;
                        case (bus.req_op)
                            MD_MUL: state_q <= RUN;
                            MD_DIVU, MD_REMU: begin
                                if (bus.req_b == '0) begin
                                    quo_q   <= '1;
                                    rem_q   <= bus.req_a;
                                    state_q <= DONE;
                                end else begin
                                    state_q <= RUN;
                                end
                            end
                            default: state_q <= DONE;
                        endcase
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (w_is_mul) begin
                        if (mplr_q[0]) begin
                            acc_q <= alu_out_i;
                        end
                        mcand_q <= {mcand_q[REG_WIDTH-2:0], 1'b0};
                        mplr_q  <= {1'b0, mplr_q[REG_WIDTH-1:1]};
                    end else begin
                        quo_q <= {quo_q[REG_WIDTH-2:0], w_rem_ge};
                        rem_q <= w_rem_ge ? alu_out_i : w_rem_sh[REG_WIDTH-1:0];
                    end
                    if (cnt_q == c_LAST_ITER) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; it is then held
                    // until the consumer takes it.
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= w_result;
                    end else if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_data_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE) && !flush_i;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign stall_o        = (state_q != IDLE) && !flush_i;

    alu_port_mux #(
        .REG_WIDTH     (REG_WIDTH),
        .ALU_CTRL_BITS (ALU_CTRL_BITS)
    ) u_alu_port_mux (
        .seq_own_i       (state_q == RUN),
        .pipe_rs1_i      (pipe_rs1_i),
        .pipe_rs2_i      (pipe_rs2_i),
        .pipe_imm_i      (pipe_imm_i),
        .pipe_alu_ctrl_i (pipe_alu_ctrl_i),
        .seq_rs1_i       (w_seq_rs1),
        .seq_rs2_i       (w_seq_rs2),
        .seq_imm_i       ('0),
        .seq_alu_ctrl_i  (w_seq_ctrl),
        .alu_rs1_o       (alu_rs1_o),
        .alu_rs2_o       (alu_rs2_o),
        .alu_imm_o       (alu_imm_o),
        .alu_ctrl_o      (alu_ctrl_o)
    );
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_sequencer
//  Description : Directed plus random checks of the mul/div sequencer against
//                an arithmetic reference, with a behavioural ALU attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_muldiv_sequencer;
    import pipeline_pkg::*;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         stall;
    logic [W-1:0] pipe_rs1, pipe_rs2, pipe_imm;
    logic [4:0]   pipe_alu_ctrl;
    logic [W-1:0] alu_rs1, alu_rs2, alu_imm, alu_out;
    logic [4:0]   alu_ctrl;

    int tests = 0;
    int fails = 0;

    ex_muldiv_sequencer_if #(.REG_WIDTH(W)) bus ();

    ex_muldiv_sequencer #(.REG_WIDTH(W), .ALU_CTRL_BITS(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .flush_i         (flush),
        .stall_o         (stall),
        .pipe_rs1_i      (pipe_rs1),
        .pipe_rs2_i      (pipe_rs2),
        .pipe_imm_i      (pipe_imm),
        .pipe_alu_ctrl_i (pipe_alu_ctrl),
        .alu_rs1_o       (alu_rs1),
        .alu_rs2_o       (alu_rs2),
        .alu_imm_o       (alu_imm),
        .alu_ctrl_o      (alu_ctrl),
        .alu_out_i       (alu_out)
    );

    // Stand-in for the external EX ALU.
    always_comb begin
        alu_out = alu_rs1 ^ alu_rs2 ^ alu_imm;
        case (alu_ctrl)
            5'b00000: alu_out = alu_rs1 + alu_rs2;
            5'b00001: alu_out = alu_rs1 - alu_rs2;
            default:  alu_out = alu_rs1 ^ alu_rs2 ^ alu_imm;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        case (op)
            2'd0:    return a * b;
            2'd1:    return (b == 0) ? {W{1'b1}} : a / b;
            2'd2:    return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] b);
        if (op == 2'd3 || (op != 2'd0 && b == 0)) return 1;
        return W + 1;
    endfunction

    task automatic rand_pipe();
        pipe_rs1      = {$urandom, $urandom};
        pipe_rs2      = {$urandom, $urandom};
        pipe_imm      = {$urandom, $urandom};
        pipe_alu_ctrl = 5'($urandom_range(2, 31));
    endtask

    function automatic bit passthrough_ok();
        return alu_ctrl === pipe_alu_ctrl && alu_rs1 === pipe_rs1 &&
               alu_rs2 === pipe_rs2 && alu_imm === pipe_imm;
    endfunction

    // Called at a negedge with the bus idle; returns at a negedge after the response is taken.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_data;
        logic [W-1:0] held;
        logic [4:0]   exp_ctrl;
        int           exp_lat;
        int           k;
        bit           stall_ok, mux_ok, hold_ok;
        exp_data = ref_result(op, a, b);
        exp_lat  = ref_latency(op, b);
        exp_ctrl = (op == 2'd0) ? 5'b00000 : 5'b00001;
        rand_pipe();
        bus.req_valid  = 1'b1;
        bus.req_op     = muldiv_op_e'(op);
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = (hold == 0);
        #1;
        check({tag, "/req_ready"}, 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        stall_ok = 1'b1;
        mux_ok = 1'b1;
        while (bus.resp_valid !== 1'b1 && k < 200) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (exp_lat > 1 && k < W) begin
                if (alu_ctrl !== exp_ctrl || alu_imm !== '0) mux_ok = 1'b0;
            end else if (!passthrough_ok()) begin
                mux_ok = 1'b0;
            end
            rand_pipe();
            @(negedge clk);
            k++;
        end
        check({tag, "/latency"}, 64'(k), 64'(exp_lat));
        check({tag, "/stall"}, 64'(stall_ok), 64'd1);
        check({tag, "/alu_mux"}, 64'(mux_ok), 64'd1);
        check({tag, "/resp_data"}, bus.resp_data, exp_data);
        if (hold > 0) begin
            held = bus.resp_data;
            hold_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (bus.resp_valid !== 1'b1 || bus.resp_data !== held ||
                    bus.req_ready !== 1'b0 || stall !== 1'b1) hold_ok = 1'b0;
            end
            check({tag, "/backpressure"}, 64'(hold_ok), 64'd1);
            bus.resp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "/idle_after"}, {61'd0, bus.resp_valid, bus.req_ready, stall}, 64'b010);
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b;
        bit           quiet;
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = MD_MUL;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        pipe_alu_ctrl  = 5'b00001;
        pipe_rs1       = 64'd9;
        pipe_rs2       = 64'd4;
        pipe_imm       = 64'd0;
        #12;
        check("reset/outputs", {60'd0, bus.resp_valid, bus.req_ready, stall, 1'b0}, 64'b0100);
        check("reset/resp_data", bus.resp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("idle/alu_ctrl", 64'(alu_ctrl), 64'd1);
        check("idle/alu_rs1", alu_rs1, 64'd9);
        check("idle/alu_rs2", alu_rs2, 64'd4);
        check("idle/stall", 64'(stall), 64'd0);

        run_op("mul7x6", 2'd0, 64'd7, 64'd6, 0);
        run_op("divu100_7", 2'd1, 64'd100, 64'd7, 0);
        run_op("remu100_7", 2'd2, 64'd100, 64'd7, 0);
        run_op("divu_max_3", 2'd1, {W{1'b1}}, 64'd3, 0);
        run_op("divu5_0", 2'd1, 64'd5, 64'd0, 0);
        run_op("remu5_0", 2'd2, 64'd5, 64'd0, 0);
        run_op("rsvd", 2'd3, 64'd123, 64'd45, 0);
        run_op("mul_hold", 2'd0, 64'hDEAD_BEEF, 64'h1234_5678_9ABC, 10);

        // Flush while idle: request must not be accepted.
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op = MD_MUL;
        #1;
        check("flush_idle/req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("flush_idle/stall", 64'(stall), 64'd0);

        // Flush in RUN cycle 20.
        bus.req_valid = 1'b1;
        bus.req_a = 64'd11;
        bus.req_b = 64'd13;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (20) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_run/stall", 64'(stall), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_run/idle", {61'd0, bus.resp_valid, bus.req_ready, stall}, 64'b010);
        quiet = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0 || stall !== 1'b0) quiet = 1'b0;
        end
        check("flush_run/no_resp", 64'(quiet), 64'd1);

        // Asynchronous reset mid-RUN.
        bus.req_valid = 1'b1;
        bus.req_a = 64'd1000;
        bus.req_b = 64'd7;
        bus.req_op = MD_DIVU;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst/outputs", {61'd0, bus.resp_valid, bus.req_ready, stall}, 64'b010);
        check("arst/passthrough", 64'(passthrough_ok()), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("mul3x3", 2'd0, 64'd3, 64'd3, 0);

        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 64'($urandom_range(1, 20));
                2:       b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
